// File: rtl/div_sched_pkg.sv
// Shared constants for the EX-stage divider controller.
//
// Contents:
//   DIV_IDLE / DIV_ITER / DIV_FIX / DIV_DONE : 2-bit FSM state encodings
//   DIV_OP_Size                              : width of the op field (2)
//   DIV_OP_MOD / DIV_OP_SIGNED               : bit positions inside the op field
//   DIV_ITER_CNT                             : quotient bits produced (32)
//   neg32()                                  : two's-complement negate, modulo 2^32
//
// Optional feature macro used by div_sched: DIV_ZERO_EARLY_EN.
package div_sched_pkg;

  localparam int DATA_W       = 32;
  localparam int DIV_OP_Size  = 2;
  localparam int DIV_ITER_CNT = 32;
  localparam int CNT_W        = 5;

  // Bit positions inside req_op.
  localparam int DIV_OP_MOD    = 1;
  localparam int DIV_OP_SIGNED = 0;

  localparam logic [1:0] DIV_IDLE = 2'd0;
  localparam logic [1:0] DIV_ITER = 2'd1;
  localparam logic [1:0] DIV_FIX  = 2'd2;
  localparam logic [1:0] DIV_DONE = 2'd3;

  function automatic logic [DATA_W-1:0] neg32(input logic [DATA_W-1:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_iter_step.sv
// One restoring-division step, purely combinational.
//
// Ports:
//   rq_in   in  64 : current {rem, quo} pair
//   divisor in  32 : unsigned divisor magnitude
//   rq_out  out 64 : {rem, quo} after shift, trial subtract and quotient-bit set
module div_iter_step
  import div_sched_pkg::*;
(
  input  logic [2*DATA_W-1:0] rq_in,
  input  logic [DATA_W-1:0]   divisor,
  output logic [2*DATA_W-1:0] rq_out
);

  // The shifted partial remainder needs 33 bits: bit 63 of the pair moves into
  // bit 32 rather than being dropped. One more bit on top holds the borrow.
  logic [DATA_W:0]   rem_sh;
  logic [DATA_W+1:0] diff;
  logic              ge;

  assign rem_sh = rq_in[2*DATA_W-1:DATA_W-1];
  assign diff   = {1'b0, rem_sh} - {2'b00, divisor};
  assign ge     = ~diff[DATA_W+1];

  // When the subtract succeeds the difference is below the divisor, so its low
  // 32 bits are the full new remainder.
  assign rq_out = {(ge ? diff[DATA_W-1:0] : rem_sh[DATA_W-1:0]),
                   rq_in[DATA_W-2:0], ge};

endmodule

// File: rtl/div_sched.sv
// Multi-cycle controller for the shared 32-bit divider (div.w/mod.w/div.wu/mod.wu).
// Runs a restoring divide one quotient bit per cycle, applies the sign fix-up
// and the divide-by-zero rule, then holds the result until downstream takes it.
//
// Ports:
//   clk        in  1  : clock
//   reset      in  1  : synchronous, active-high reset
//   flush      in  1  : synchronous cancel of in-flight or held operation
//   req_valid  in  1  : EX holds a valid divide/mod op
//   req_op     in  2  : bit1 = mod/div, bit0 = signed/unsigned
//   req_src1   in  32 : dividend
//   req_src2   in  32 : divisor
//   req_ready  out 1  : request accepted on an edge with req_valid && req_ready
//   res_valid  out 1  : result available
//   res_data   out 32 : quotient or remainder, chosen by the latched op
//   res_ready  in  1  : downstream accepts the result
//   busy       out 1  : state is not IDLE
//   dbg_state  out 2  : current FSM state (debug)
//
// Macro: DIV_ZERO_EARLY_EN -- when defined, a divide by zero skips ITER and
// goes straight from accept to FIX.
//
// Handshake: both sides are valid/ready. A request transfers on an edge where
// req_valid && req_ready && !flush; a result transfers on an edge where
// res_valid && res_ready && !flush. res_valid never drops and res_data never
// changes before its transfer except by flush or reset.
module div_sched
  import div_sched_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   flush,
  input  logic                   req_valid,
  input  logic [DIV_OP_Size-1:0] req_op,
  input  logic [DATA_W-1:0]      req_src1,
  input  logic [DATA_W-1:0]      req_src2,
  output logic                   req_ready,
  output logic                   res_valid,
  output logic [DATA_W-1:0]      res_data,
  input  logic                   res_ready,
  output logic                   busy,
  output logic [1:0]             dbg_state
);

  logic [1:0]             state;
  logic [CNT_W-1:0]       cnt;
  logic [DIV_OP_Size-1:0] op_q;
  logic                   s1_q;
  logic                   s2_q;
  logic                   dz_q;
  logic [DATA_W-1:0]      src1_q;
  logic [DATA_W-1:0]      dvsr_q;
  logic [2*DATA_W-1:0]    rq_q;
  logic [2*DATA_W-1:0]    rq_next;
  logic [DATA_W-1:0]      res_data_q;

  logic              accept;
  logic              req_signed;
  logic              s1_in;
  logic              s2_in;
  logic              dz_in;
  logic [DATA_W-1:0] abs1_in;
  logic [DATA_W-1:0] abs2_in;
  logic [1:0]        accept_state;
  logic [DATA_W-1:0] quo_fix;
  logic [DATA_W-1:0] rem_fix;
  logic [DATA_W-1:0] result;

  assign req_ready = (state == DIV_IDLE) || (state == DIV_DONE && res_ready);
  assign accept    = req_valid && req_ready && !flush;
  assign res_valid = (state == DIV_DONE);
  assign res_data  = res_data_q;
  assign busy      = (state != DIV_IDLE);
  assign dbg_state = state;

  assign req_signed = req_op[DIV_OP_SIGNED];
  assign s1_in      = req_src1[DATA_W-1] & req_signed;
  assign s2_in      = req_src2[DATA_W-1] & req_signed;
  assign dz_in      = (req_src2 == '0);
  assign abs1_in    = s1_in ? neg32(req_src1) : req_src1;
  assign abs2_in    = s2_in ? neg32(req_src2) : req_src2;

`ifdef DIV_ZERO_EARLY_EN
  assign accept_state = dz_in ? DIV_FIX : DIV_ITER;
`else
  assign accept_state = DIV_ITER;
`endif

  div_iter_step u_step (
    .rq_in   (rq_q),
    .divisor (dvsr_q),
    .rq_out  (rq_next)
  );

  // Sign fix-up; 0x80000000 / -1 wraps to 0x80000000 remainder 0 on its own.
  always_comb begin
    quo_fix = (s1_q ^ s2_q) ? neg32(rq_q[DATA_W-1:0]) : rq_q[DATA_W-1:0];
    rem_fix = s1_q ? neg32(rq_q[2*DATA_W-1:DATA_W]) : rq_q[2*DATA_W-1:DATA_W];
    if (dz_q) begin
      quo_fix = '1;
      rem_fix = src1_q;
    end
    result = op_q[DIV_OP_MOD] ? rem_fix : quo_fix;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DIV_IDLE;
      cnt        <= '0;
      op_q       <= '0;
      s1_q       <= 1'b0;
      s2_q       <= 1'b0;
      dz_q       <= 1'b0;
      src1_q     <= '0;
      dvsr_q     <= '0;
      rq_q       <= '0;
      res_data_q <= '0;
    end else if (flush) begin
      state <= DIV_IDLE;
    end else begin
      case (state)
        DIV_IDLE, DIV_DONE: begin
          if (accept) begin
            state  <= accept_state;
            cnt    <= CNT_W'(DIV_ITER_CNT - 1);
            op_q   <= req_op;
            s1_q   <= s1_in;
            s2_q   <= s2_in;
            dz_q   <= dz_in;
            src1_q <= req_src1;
            dvsr_q <= abs2_in;
            rq_q   <= {{DATA_W{1'b0}}, abs1_in};
          end else if (state == DIV_DONE && res_ready) begin
            state <= DIV_IDLE;
          end
        end
        DIV_ITER: begin
          rq_q <= rq_next;
          if (cnt == '0) begin
            state <= DIV_FIX;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        DIV_FIX: begin
          res_data_q <= result;
          state      <= DIV_DONE;
        end
        default: state <= DIV_IDLE;
      endcase
    end
  end

endmodule
